req_dispatch4: RTL



---
 rtl/req_dispatch4.sv | 139 +++++++++++++
 1 files changed

// File: rtl/req_dispatch4.sv
// req_dispatch4: four-line sticky request collector and dispatcher.
// Latches request pulses, issues one index at a time over valid/ready,
// and counts cycles in which a request hit an already-pending bit.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   in       request pulses, bit k from source k
//   ready    consumer accepts pos when valid=1
//   pos      registered index of the dispatched request
//   valid    pos holds a dispatched request
//   pending  registered sticky pending bits
//   drop_cnt saturating count of cycles with at least one drop
//
// Optional feature macro: ROUND_ROBIN_EN
//   defined   -> round-robin selection after the last granted index
//   undefined -> fixed priority, lowest index wins
module req_dispatch4 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       in,
   input  logic             ready,
   output logic [1:0]       pos,
   output logic             valid,
   output logic [3:0]       pending,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [1:0] pos_nx;
   logic       hs;
   logic [3:0] grant_clr;
   logic [3:0] remain;
   logic [3:0] pend_nx;
   logic       drop;
   logic [1:0] sel;

   function automatic logic [1:0] sel_fixed(
      input logic [3:0] r
   );
      logic [1:0] idx;
      if (r[0])
         idx = 2'd0;
      else if (r[1])
         idx = 2'd1;
      else if (r[2])
         idx = 2'd2;
      else
         idx = 2'd3;
      return idx;
   endfunction

   assign valid = (state == HOLD);
   assign hs    = valid && ready;

   always_comb begin
      grant_clr = 4'b0000;
      if (hs)
         grant_clr = 4'b0001 << pos;
   end

   assign remain  = pending & ~grant_clr;
   assign pend_nx = remain | in;

   // A set on a bit being granted this cycle is a fresh request,
   // so only bits that stay pending can drop.
   assign drop = |(in & remain);

`ifdef ROUND_ROBIN_EN
   logic [1:0] last_grant;
   logic [1:0] ptr;
   logic [1:0] start;
   logic [7:0] dbl;
   logic [3:0] rot;

   // On a handshake the pointer is about to become pos, so the
   // back-to-back pick already searches from just past pos.
   assign ptr   = hs ? pos : last_grant;
   assign start = ptr + 2'd1;
   assign dbl   = {remain, remain} >> start;
   assign rot   = dbl[3:0];
   assign sel   = sel_fixed(rot) + start;

   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= 2'd3;
      else if (hs)
         last_grant <= pos;
   end
`else
   assign sel = sel_fixed(remain);
`endif

   always_comb begin
      state_nx = state;
      pos_nx   = pos;
      unique case (state)
         IDLE: begin
            if (pending != 4'b0000) begin
               pos_nx   = sel;
               state_nx = HOLD;
            end
         end
         HOLD: begin
            if (ready) begin
               if (remain != 4'b0000)
                  pos_nx = sel;
               else
                  state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pos      <= 2'd0;
         pending  <= 4'b0000;
         drop_cnt <= '0;
      end else begin
         state   <= state_nx;
         pos     <= pos_nx;
         pending <= pend_nx;
         if (drop && (drop_cnt != {CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule
